// File: rtl/zle_pkg.sv
// Shared constants for the zero run-length encoder/decoder pair.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: state encodings, token field positions, maximum run length.
package zle_pkg;

    localparam int ZLE_DATA_W  = 7;
    // Token MSB selects between literal (0) and zero run (1).
    localparam int TOK_RUN_BIT = ZLE_DATA_W;
    localparam int MAX_RUN     = (1 << ZLE_DATA_W) - 1;

    localparam logic [1:0] S_GET = 2'd0;
    localparam logic [1:0] S_LIT = 2'd1;
    localparam logic [1:0] S_RUN = 2'd2;

    typedef struct packed {
        logic                  run;
        logic [ZLE_DATA_W-1:0] val;
    } tok_t;

endpackage

// File: rtl/zld_xcb_fsm.sv
// Control FSM of the zero run-length decoder: next state, i_b, o_v, stateo.
// Latency: i_b and o_v are combinational from state, i_v, o_b and datapath flags.
// Backpressure: o_b high holds S_LIT/S_RUN with o_v low; i_b is low only on a consume cycle.
// Ports: clock/reset, i_v, o_b, flags from the datapath in; i_b, o_v, stateo out.
module zld_xcb_fsm
    import zle_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_v,
    input  logic       o_b,
    input  logic       f_get_run,
    input  logic       f_get_cnt_eq_0,
    input  logic       f_run_cnt_eq_1,
    output logic       i_b,
    output logic       o_v,
    output logic [1:0] stateo
);

    logic [1:0] state;
    logic [1:0] nxt;

    always_comb begin
        nxt = state;
        i_b = 1'b1;
        o_v = 1'b0;
        case (state)
            S_GET: begin
                if (i_v) begin
                    i_b = 1'b0;
                    if (!f_get_run)
                        nxt = S_LIT;
                    else if (!f_get_cnt_eq_0)
                        nxt = S_RUN;
                    else
                        nxt = S_GET;   // zero-length run: consumed and dropped
                end
            end
            S_LIT: begin
                if (!o_b) begin
                    o_v = 1'b1;
                    nxt = S_GET;
                end
            end
            S_RUN: begin
                if (!o_b) begin
                    o_v = 1'b1;
                    if (f_run_cnt_eq_1)
                        nxt = S_GET;
                end
            end
            default: nxt = S_GET;    // unreachable encoding: stay inert
        endcase
        // Handshake outputs are forced idle for the whole reset window,
        // not just from the first edge, so reset takes effect immediately.
        if (!reset) begin
            i_b = 1'b1;
            o_v = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_GET;
        else
            state <= nxt;
    end

    assign stateo = state;

endmodule

// File: rtl/zld_xcb.sv
// Zero run-length decoder: expands literal / zero-run tokens into a value stream.
// Latency: first value one cycle after the token is consumed; one S_GET bubble per token.
// Backpressure: o_b stalls the current output; input stays busy until the token is fully emitted.
// Ports: clock, reset (async active-low), i_v/i_b/i_d token in, o_v/o_b/o_d value out, stateo debug.
// Optional: define ZLD_ERR_EN to add sticky output err, set on consuming token 0x80 or 0x00.
module zld_xcb
    import zle_pkg::*;
#(
    parameter int DATA_W = ZLE_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_v,
    output logic              i_b,
    input  logic [DATA_W:0]   i_d,
    output logic              o_v,
    input  logic              o_b,
    output logic [DATA_W-1:0] o_d,
    output logic [1:0]        stateo
`ifdef ZLD_ERR_EN
    ,
    output logic              err
`endif
);

    logic [DATA_W:0]   tok;
    logic [DATA_W-1:0] cnt;
    logic              load;
    logic              dec;
    logic              f_get_run;
    logic              f_get_cnt_eq_0;
    logic              f_run_cnt_eq_1;

    assign f_get_run      = i_d[DATA_W];
    assign f_get_cnt_eq_0 = (i_d[DATA_W-1:0] == '0);
    assign f_run_cnt_eq_1 = (cnt == {{(DATA_W-1){1'b0}}, 1'b1});

    zld_xcb_fsm u_fsm (
        .clock          (clock),
        .reset          (reset),
        .i_v            (i_v),
        .o_b            (o_b),
        .f_get_run      (f_get_run),
        .f_get_cnt_eq_0 (f_get_cnt_eq_0),
        .f_run_cnt_eq_1 (f_run_cnt_eq_1),
        .i_b            (i_b),
        .o_v            (o_v),
        .stateo         (stateo)
    );

    // i_b is low exactly on a consume cycle, so it doubles as the load strobe.
    assign load = (stateo == S_GET) && !i_b;
    // cnt only steps on a real transfer; the FSM leaves S_RUN when cnt==1,
    // so it never decrements past 1 and cannot wrap.
    assign dec  = (stateo == S_RUN) && o_v;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tok <= '0;
            cnt <= '0;
        end else if (load) begin
            tok <= i_d;
            cnt <= i_d[DATA_W-1:0];
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Literal value only while the held token is a literal; runs emit zero.
    assign o_d = ((stateo == S_LIT) && !tok[DATA_W]) ? tok[DATA_W-1:0] : '0;

`ifdef ZLD_ERR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            err <= 1'b0;
        else if (load && (i_d[DATA_W-1:0] == '0))
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_zld_xcb.sv
module tb_zld_xcb;

    logic       clock;
    logic       reset;
    logic       i_v;
    logic       i_b;
    logic [7:0] i_d;
    logic       o_v;
    logic       o_b;
    logic [6:0] o_d;
    logic [1:0] stateo;
`ifdef ZLD_ERR_EN
    logic       err;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    zld_xcb #(.DATA_W(7)) dut (
        .clock  (clock),
        .reset  (reset),
        .i_v    (i_v),
        .i_b    (i_b),
        .i_d    (i_d),
        .o_v    (o_v),
        .o_b    (o_b),
        .o_d    (o_d),
        .stateo (stateo)
`ifdef ZLD_ERR_EN
        ,
        .err    (err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs sampled 1ns later.
    task automatic drive(input logic v, input logic [7:0] d, input logic b);
        i_v = v;
        i_d = d;
        o_b = b;
        #1;
    endtask

    task automatic next_cyc;
        @(negedge clock);
    endtask

    initial begin
        int pulses;
        int nz;
        int viol;
        int runlen;

        reset = 1'b0;
        drive(1'b1, 8'h05, 1'b0);
        chk("rst_i_b",   i_b,    1);
        chk("rst_o_v",   o_v,    0);
        chk("rst_o_d",   o_d,    0);
        chk("rst_state", stateo, 0);
        next_cyc;
        reset = 1'b1;

        // Literals 0x05 and 0x7F back to back.
        drive(1'b1, 8'h05, 1'b0);
        chk("lit1_consume_i_b", i_b, 0);
        chk("lit1_consume_o_v", o_v, 0);
        next_cyc;
        drive(1'b1, 8'h7F, 1'b0);
        chk("lit1_out_o_v",  o_v,    1);
        chk("lit1_out_o_d",  o_d,    5);
        chk("lit1_out_i_b",  i_b,    1);
        chk("lit1_out_state", stateo, 1);
        next_cyc;
        drive(1'b1, 8'h7F, 1'b0);
        chk("lit2_consume_i_b", i_b, 0);
        chk("lit2_consume_o_v", o_v, 0);
        next_cyc;
        drive(1'b0, 8'h00, 1'b0);
        chk("lit2_out_o_v", o_v, 1);
        chk("lit2_out_o_d", o_d, 127);
        next_cyc;

        // Short run 0x83 then literal 0x02.
        drive(1'b1, 8'h83, 1'b0);
        chk("run3_consume_i_b", i_b, 0);
        next_cyc;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h02, 1'b0);
            chk("run3_o_v",   o_v,    1);
            chk("run3_o_d",   o_d,    0);
            chk("run3_i_b",   i_b,    1);
            chk("run3_state", stateo, 2);
            next_cyc;
        end
        drive(1'b1, 8'h02, 1'b0);
        chk("run3_back_get", stateo, 0);
        chk("run3_next_i_b", i_b,    0);
        chk("run3_next_o_v", o_v,    0);
        next_cyc;
        drive(1'b0, 8'h00, 1'b0);
        chk("run3_lit_o_v", o_v, 1);
        chk("run3_lit_o_d", o_d, 2);
        next_cyc;

        // Maximum run 0xFF: 127 zeros, consecutive.
        drive(1'b1, 8'hFF, 1'b0);
        chk("max_consume_i_b", i_b, 0);
        next_cyc;
        pulses = 0; nz = 0; runlen = 0;
        for (int k = 0; k < 200; k++) begin
            drive(1'b0, 8'h00, 1'b0);
            if (stateo != 2'd2) break;
            runlen++;
            if (o_v) pulses++;
            if (o_d !== 7'd0) nz++;
            next_cyc;
        end
        chk("max_pulses",   pulses, 127);
        chk("max_cycles",   runlen, 127);
        chk("max_nonzero",  nz,     0);
        chk("max_end_state", stateo, 0);
        chk("max_end_o_v",   o_v,    0);
        next_cyc;

        // Run of 4 with o_b high on alternate cycles; next token waits.
        drive(1'b1, 8'h84, 1'b0);
        chk("bp_consume_i_b", i_b, 0);
        next_cyc;
        pulses = 0; viol = 0; runlen = 0;
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 8'h01, (k % 2) == 0);
            if (stateo != 2'd2) break;
            runlen++;
            if (o_v) pulses++;
            if (o_v && o_b) viol++;
            if (!i_b) viol++;
            next_cyc;
        end
        chk("bp_pulses",     pulses, 4);
        chk("bp_cycles",     runlen, 8);
        chk("bp_violations", viol,   0);
        chk("bp_next_i_b",   i_b,    0);
        next_cyc;
        drive(1'b0, 8'h00, 1'b0);
        chk("bp_lit_o_v", o_v, 1);
        chk("bp_lit_o_d", o_d, 1);
        next_cyc;

        // Reserved zero-length run 0x80 then literal 0x09.
        drive(1'b1, 8'h80, 1'b0);
        chk("rsv_consume_i_b", i_b, 0);
        next_cyc;
        drive(1'b1, 8'h09, 1'b0);
        chk("rsv_state", stateo, 0);
        chk("rsv_o_v",   o_v,    0);
        chk("rsv_i_b",   i_b,    0);
`ifdef ZLD_ERR_EN
        chk("rsv_err_set", err, 1);
`endif
        next_cyc;
        drive(1'b0, 8'h00, 1'b0);
        chk("rsv_lit_o_v", o_v, 1);
        chk("rsv_lit_o_d", o_d, 9);
        next_cyc;
`ifdef ZLD_ERR_EN
        drive(1'b0, 8'h00, 1'b0);
        chk("rsv_err_sticky", err, 1);
`endif

        // Zero literal 0x00 passes through as value 0.
        drive(1'b1, 8'h00, 1'b0);
        chk("zlit_consume_i_b", i_b, 0);
        next_cyc;
        drive(1'b0, 8'h00, 1'b0);
        chk("zlit_o_v",   o_v,    1);
        chk("zlit_o_d",   o_d,    0);
        chk("zlit_state", stateo, 1);
        next_cyc;

        // Reset mid-run after 2 of 100 zeros.
        drive(1'b1, 8'hE4, 1'b0);
        chk("arst_consume_i_b", i_b, 0);
        next_cyc;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 8'h00, 1'b0);
            chk("arst_run_o_v", o_v, 1);
            next_cyc;
        end
        drive(1'b1, 8'h01, 1'b0);
        chk("arst_pre_state", stateo, 2);
        reset = 1'b0;
        #1;
        chk("arst_o_v",   o_v,    0);
        chk("arst_i_b",   i_b,    1);
        chk("arst_state", stateo, 0);
        chk("arst_o_d",   o_d,    0);
`ifdef ZLD_ERR_EN
        chk("arst_err", err, 0);
`endif
        next_cyc;
        reset = 1'b1;
        drive(1'b1, 8'h01, 1'b0);
        chk("post_consume_i_b", i_b, 0);
        next_cyc;
        drive(1'b0, 8'h00, 1'b0);
        chk("post_o_v", o_v, 1);
        chk("post_o_d", o_d, 1);
        next_cyc;
        drive(1'b0, 8'h00, 1'b0);
        chk("post_idle_o_v",   o_v,    0);
        chk("post_idle_state", stateo, 0);
        next_cyc;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
